alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational Alu instance between two requesters: port 0 (pipeline
//   execute stage) and port 1 (merge-sort compare/address engine).
//   Round-robin grant; valid/ready request handshake; one operation in flight.
//   Drives the Alu operand/control inputs from registered copies and captures
//   alu_out into a per-port response register held until that port accepts it.
// PARAMETERS
//   WIDTH      32  operand/result width; must match the Alu datapath
//   RR_INIT    1   reset value of last_grant, so port 0 wins the first contention
// PORTS
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   req_valid    in   2      per-port request valid; bit k = port k
//   req_ready    out  2      per-port accept strobe
//   req_a0/req_a1 in  WIDTH  operand A, port 0 / port 1
//   req_b0/req_b1 in  WIDTH  operand B, port 0 / port 1
//   req_ctl0/req_ctl1 in 3   Alu control code: 000 add, 001 sll, 010 sra, 011 sub,
//                            100 slt, 101 srl, 110 or, 111 sge
//   rsp_valid    out  2      per-port result valid
//   rsp_ready    in   2      per-port result accept
//   rsp_data0/rsp_data1 out WIDTH  result for port 0 / port 1
//   alu_a, alu_b out  WIDTH  driven to the Alu inputA/inputB
//   alu_ctl      out  3      driven to the Alu control input
//   alu_out      in   WIDTH  Alu result (combinational, same cycle)
//   busy         out  1      high whenever state != IDLE
// BEHAVIOUR
//   FSM: IDLE -> EXEC -> RESP -> IDLE. Reset forces IDLE from any state.
//   IDLE:
//     - Arbitration (combinational): if exactly one req_valid bit is set, grant that
//       port. If both are set, grant the port != last_grant.
//     - req_ready[g] = 1 for the granted port only. req_ready = 00 outside IDLE.
//     - Accept = req_valid[g] & req_ready[g]: latch a/b/ctl into op regs,
//       set owner = g, set last_grant = g, go to EXEC.
//   EXEC (exactly 1 cycle):
//     - alu_a/alu_b/alu_ctl driven from the op regs.
//     - At the clock edge, capture alu_out into rsp_data[owner], set
//       rsp_valid[owner] = 1, go to RESP.
//   RESP:
//     - rsp_valid[owner] stays high and rsp_data stays stable until rsp_ready[owner].
//     - On that handshake: clear rsp_valid, go to IDLE.
//     - rsp_ready on the non-owner port is ignored.
//   Latency: accept at edge N; rsp_valid high after edge N+1.
//     - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP).
//   Outside EXEC: alu_a/alu_b/alu_ctl still show the op regs (no glitching to 0).
//   rsp_data of the non-owner port keeps its last value (not cleared).
//   Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
//     - A port is never starved longer than one foreign operation.
//   Reset (synchronous, also mid-operation):
//     - state = IDLE, req_ready = 00, rsp_valid = 00, busy = 0.
//     - rsp_data0/1 = 0, alu_a = alu_b = 0, alu_ctl = 000, last_grant = RR_INIT.
//     - An in-flight op is dropped; no response is produced.
//   Request signals may change while not accepted; only the accepted-cycle values
//   are used.
//   Width: no arithmetic inside this block. Results pass through unmodified
//   (slt/sge yield 0/1 zero-extended).
// CONFIGURATION
//   ALU_ARB_STATS_EN defined:
//     - Adds outputs grant_cnt0, grant_cnt1 (16 bits each): accepted-request counts
//       per port.
//     - Saturating at 16'hFFFF; cleared by reset.
//     - Adds output contention_cnt (16 bits, saturating): IDLE cycles with
//       req_valid == 11.
//   ALU_ARB_STATS_EN undefined:
//     - Ports and counters are absent. Behaviour is otherwise identical.
// TESTING
//   1. Port0 add a=5, b=7, rsp_ready0=1 -> req_ready0 in cycle 0; rsp_valid0 after
//      edge 1, rsp_data0 = 12; rsp_valid1 stays 0.
//   2. Both valid from reset, sub 10-3 on p0, sll 1<<4 on p1 -> p0 granted first
//      (rsp_data0 = 7), then p1 (rsp_data1 = 16); grants alternate over 6 ops.
//   3. Port1 slt a=-1, b=1 with rsp_ready1 = 0 for 5 cycles -> rsp_valid1 held,
//      data = 1, busy = 1, req_ready = 00 throughout; IDLE one cycle after the
//      rsp_ready1 pulse.
//   4. Reset asserted during EXEC of sra 0x80000000>>4 -> next cycle: state IDLE,
//      rsp_valid = 00, rsp_data0 = 0; no response ever appears for that op.
//   5. Port0 changes a/b after accept -> result reflects the accepted-cycle
//      operands (or 0xF0|0x0F = 0xFF).
//   6. [ALU_ARB_STATS_EN] 3 p0 + 2 p1 ops with 2 contention cycles ->
//      grant_cnt0 = 3, grant_cnt1 = 2, contention_cnt = 2; counts 0 after reset.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational Alu between two requesters, one op in flight.
// Optional ALU_ARB_STATS_EN adds saturating grant and contention counters.
module alu_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          RR_INIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_ctl0,
  input  logic [2:0]       req_ctl1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data0,
  output logic [WIDTH-1:0] rsp_data1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
  output logic [15:0]      contention_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data0;
  logic [WIDTH-1:0] r_rsp_data1;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [2:0]       r_op_ctl;

  logic             w_idle;
  logic             w_grant;
  logic             w_any;
  logic             w_accept;

  // Single requester wins outright; on contention the port that did not win last time goes
  always_comb begin
    w_grant = 1'b0;
    w_any   = 1'b0;
    unique case (req_valid)
      2'b01:   begin w_grant = 1'b0;          w_any = 1'b1; end
      2'b10:   begin w_grant = 1'b1;          w_any = 1'b1; end
      2'b11:   begin w_grant = ~r_last_grant; w_any = 1'b1; end
      default: begin w_grant = 1'b0;          w_any = 1'b0; end
    endcase
  end

  assign w_idle    = (r_state == IDLE);
  assign req_ready = (w_idle && w_any) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_accept  = |(req_valid & req_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= RR_INIT;
      r_owner      <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rsp_data0  <= '0;
      r_rsp_data1  <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctl     <= 3'b000;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a       <= w_grant ? req_a1 : req_a0;
            r_op_b       <= w_grant ? req_b1 : req_b0;
            r_op_ctl     <= w_grant ? req_ctl1 : req_ctl0;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          if (r_owner) r_rsp_data1 <= alu_out;
          else         r_rsp_data0 <= alu_out;
          r_rsp_valid[r_owner] <= 1'b1;
          r_state              <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data0 = r_rsp_data0;
  assign rsp_data1 = r_rsp_data1;
  assign alu_a     = r_op_a;
  assign alu_b     = r_op_b;
  assign alu_ctl   = r_op_ctl;
  assign busy      = ~w_idle;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;
  logic [15:0] r_contention_cnt;

  // Saturating usage counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant_cnt0     <= 16'd0;
      r_grant_cnt1     <= 16'd0;
      r_contention_cnt <= 16'd0;
    end else begin
      if (w_accept && !w_grant && r_grant_cnt0 != 16'hFFFF)
        r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_accept && w_grant && r_grant_cnt1 != 16'hFFFF)
        r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
      if (w_idle && req_valid == 2'b11 && r_contention_cnt != 16'hFFFF)
        r_contention_cnt <= r_contention_cnt + 16'd1;
    end
  end

  assign grant_cnt0     = r_grant_cnt0;
  assign grant_cnt1     = r_grant_cnt1;
  assign contention_cnt = r_contention_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural Alu closing the loop.
module tb_alu_share_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [2:0]  req_ctl0, req_ctl1, alu_ctl;
  logic [31:0] rsp_data0, rsp_data1, alu_a, alu_b, alu_out;
  logic        busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, contention_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_share_arbiter #(.WIDTH(32), .RR_INIT(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_ctl0(req_ctl0), .req_ctl1(req_ctl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_out(alu_out),
    .busy(busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .contention_cnt(contention_cnt)
`endif
  );

  always #5 clock = ~clock;

  always_comb begin
    alu_out = 32'd0;
    case (alu_ctl)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a << alu_b[4:0];
      3'b010: alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
      3'b011: alu_out = alu_a - alu_b;
      3'b100: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'b101: alu_out = alu_a >> alu_b[4:0];
      3'b110: alu_out = alu_a | alu_b;
      default: alu_out = {31'd0, $signed(alu_a) >= $signed(alu_b)};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction: accept, execute, respond, return to IDLE
  task automatic do_op(input logic [1:0] v, input logic g, input logic [31:0] d);
    req_valid = v;
    rsp_ready = 2'b11;
    #1;
    chk("op_req_ready", 32'(req_ready), g ? 32'd2 : 32'd1);
    tick();
    req_valid = 2'b00;
    chk("op_busy_exec", 32'(busy), 32'd1);
    tick();
    chk("op_rsp_valid", 32'(rsp_valid), g ? 32'd2 : 32'd1);
    chk("op_rsp_data", g ? rsp_data1 : rsp_data0, d);
    tick();
    chk("op_idle", 32'(busy), 32'd0);
    chk("op_rsp_clear", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_ctl0 = '0; req_ctl1 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_data0", rsp_data0, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctl", 32'(alu_ctl), 32'd0);

    // 1: port 0 add 5+7
    req_a0 = 32'd5; req_b0 = 32'd7; req_ctl0 = 3'b000;
    req_valid = 2'b01; rsp_ready = 2'b01;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    chk("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data0", rsp_data0, 32'd12);
    tick();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_rsp_clear", 32'(rsp_valid), 32'd0);

    // 2: contention from reset, strict alternation starting at port 0
    reset = 1'b1; tick(); reset = 1'b0;
    req_a0 = 32'd10; req_b0 = 32'd3; req_ctl0 = 3'b011;
    req_a1 = 32'd1;  req_b1 = 32'd4; req_ctl1 = 3'b001;
    for (int i = 0; i < 6; i++) do_op(2'b11, 1'(i % 2), (i % 2) ? 32'd16 : 32'd7);

    // 3: port 1 slt -1<1 held while rsp_ready1 stays low
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_ctl1 = 3'b100;
    req_valid = 2'b10; rsp_ready = 2'b00;
    tick();
    req_valid = 2'b01;
    tick();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd2);
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i == 2) ? 2'b01 : 2'b00;
      tick();
      chk("t3_hold_valid", 32'(rsp_valid), 32'd2);
      chk("t3_hold_data", rsp_data1, 32'd1);
      chk("t3_hold_busy", 32'(busy), 32'd1);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_rsp_clear", 32'(rsp_valid), 32'd0);
    chk("t3_ready_again", 32'(req_ready), 32'd1);
    req_valid = 2'b00;

    // 4: reset during EXEC drops the op
    chk("t4_pre_data0", rsp_data0, 32'd7);
    req_a0 = 32'h8000_0000; req_b0 = 32'd4; req_ctl0 = 3'b010;
    req_valid = 2'b01; rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    chk("t4_exec_alu_a", alu_a, 32'h8000_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rsp_data0", rsp_data0, 32'd0);
    chk("t4_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // 5: operands changed after accept are ignored
    req_a0 = 32'hF0; req_b0 = 32'h0F; req_ctl0 = 3'b110;
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1;
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00; req_a0 = 32'd0; req_b0 = 32'd0; req_ctl0 = 3'b000;
    tick();
    chk("t5_rsp_data0", rsp_data0, 32'hFF);
    chk("t5_alu_held", alu_a, 32'hF0);
    rsp_ready = 2'b01;
    tick();
    chk("t5_idle", 32'(busy), 32'd0);

    // 6: 3 port-0 and 2 port-1 ops, two of them under contention
    reset = 1'b1; tick(); reset = 1'b0;
`ifdef ALU_ARB_STATS_EN
    chk("t6_cnt0_rst", 32'(grant_cnt0), 32'd0);
    chk("t6_cnt1_rst", 32'(grant_cnt1), 32'd0);
    chk("t6_cont_rst", 32'(contention_cnt), 32'd0);
`endif
    req_a0 = 32'd9; req_b0 = 32'd2; req_ctl0 = 3'b101;
    req_a1 = 32'hFFFF_FFF8; req_b1 = 32'd3; req_ctl1 = 3'b111;
    do_op(2'b11, 1'b0, 32'd2);
    do_op(2'b11, 1'b1, 32'd0);
    do_op(2'b01, 1'b0, 32'd2);
    do_op(2'b01, 1'b0, 32'd2);
    do_op(2'b10, 1'b1, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("t6_cnt0", 32'(grant_cnt0), 32'd3);
    chk("t6_cnt1", 32'(grant_cnt1), 32'd2);
    chk("t6_cont", 32'(contention_cnt), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
